mult_iter: RTL

// - Multi-cycle iterative HI/LO multiplier for the execute stage; signed/unsigned W x W -> 2W product.
// - Processes STEP multiplier bits per cycle, trading latency for area and timing versus a single-cycle array.
// - Uses a valid/ready handshake on both sides and accepts a pipeline flush on exception or branch cancel.

---
 rtl/mult_iter_pkg.sv | 22 ++
 rtl/mult_iter_if.sv | 37 +++
 rtl/mult_iter_step.sv | 19 +
 rtl/mult_iter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mult_iter_pkg.sv
// Shared types and helpers for the iterative HI/LO multiplier.
package mult_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] ACC_NONE = 2'b00;
  localparam logic [1:0] ACC_MADD = 2'b01;
  localparam logic [1:0] ACC_MSUB = 2'b10;

  // Widest operand abs_w() can handle; callers extend into this width first.
  localparam int unsigned MAXW = 128;

  function automatic logic [MAXW-1:0] abs_w(input logic [MAXW-1:0] x);
    return x[MAXW-1] ? ('0 - x) : x;
  endfunction

endpackage

// File: rtl/mult_iter_if.sv
// Request/result handshake bundle for mult_iter; MULT_ACC_EN adds the accumulate operands.
interface mult_iter_if #(
  parameter int unsigned W = 32
);
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_opr1;
  logic [W-1:0] i_opr2;
  logic         i_is_unsigned;
  logic         i_flush;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_hi_result;
  logic [W-1:0] o_lo_result;
`ifdef MULT_ACC_EN
  logic [1:0]   i_acc_mode;
  logic [W-1:0] i_acc_hi;
  logic [W-1:0] i_acc_lo;
`endif

  modport slave (
    input  i_valid, i_opr1, i_opr2, i_is_unsigned, i_flush, i_ready,
`ifdef MULT_ACC_EN
    input  i_acc_mode, i_acc_hi, i_acc_lo,
`endif
    output o_ready, o_valid, o_hi_result, o_lo_result
  );

  modport master (
    output i_valid, i_opr1, i_opr2, i_is_unsigned, i_flush, i_ready,
`ifdef MULT_ACC_EN
    output i_acc_mode, i_acc_hi, i_acc_lo,
`endif
    input  o_ready, o_valid, o_hi_result, o_lo_result
  );

endinterface

// File: rtl/mult_iter_step.sv
// One radix-2^STEP partial-product step: acc_o = acc_i + (mag1 * digit) << (cnt*STEP).
module mult_iter_step #(
  parameter int unsigned W    = 32,
  parameter int unsigned STEP = 2,
  parameter int unsigned CW   = 5
) (
  input  logic [W-1:0]    mag1_i,
  input  logic [STEP-1:0] digit_i,
  input  logic [CW-1:0]   cnt_i,
  input  logic [2*W-1:0]  acc_i,
  output logic [2*W-1:0]  acc_o
);

  logic [2*W-1:0] part;

  assign part  = {{W{1'b0}}, mag1_i} * {{(2*W-STEP){1'b0}}, digit_i};
  assign acc_o = acc_i + (part << (cnt_i * STEP));

endmodule

// File: rtl/mult_iter.sv
// Multi-cycle signed/unsigned W x W -> 2W multiplier, STEP multiplier bits per cycle.
// Optional MADD/MSUB accumulate enabled by defining MULT_ACC_EN.
module mult_iter
  import mult_iter_pkg::*;
#(
  parameter int unsigned W    = 32,
  parameter int unsigned STEP = 2
) (
  input logic      i_clk,
  input logic      i_rst_n,
  mult_iter_if.slave bus
);

  localparam int unsigned NITER = W / STEP;
  localparam int unsigned CW    = $clog2(NITER + 1);

  if ((W % STEP) != 0) begin : g_bad_step
    $error("mult_iter: W must be a multiple of STEP");
  end
  if (W > MAXW) begin : g_bad_width
    $error("mult_iter: W exceeds MAXW");
  end

  state_e         state_q, state_d;
  logic [W-1:0]   mag1_q, mag1_d;
  logic [W-1:0]   mplr_q, mplr_d;
  logic           neg_q, neg_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           valid_q, valid_d;
`ifdef MULT_ACC_EN
  logic [1:0]     amode_q, amode_d;
  logic [2*W-1:0] aval_q, aval_d;
`endif

  logic           accept;
  logic [MAXW-1:0] opr1_x, opr2_x;
  logic [2*W-1:0] step_acc;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] result;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    if (bus.i_flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (bus.i_valid) state_d = CALC;
        CALC:    if (cnt_q == CW'(NITER - 1)) state_d = FIX;
        FIX:     state_d = DONE;
        DONE:    if (bus.i_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.o_ready     = (state_q == IDLE);
    bus.o_valid     = valid_q;
    bus.o_hi_result = hi_q;
    bus.o_lo_result = lo_q;
  end

  assign accept = (state_q == IDLE) && bus.i_valid && !bus.i_flush;

  // Extend into the helper's width so abs_w() also covers the most-negative value
  assign opr1_x = bus.i_is_unsigned ? MAXW'(bus.i_opr1) : MAXW'($signed(bus.i_opr1));
  assign opr2_x = bus.i_is_unsigned ? MAXW'(bus.i_opr2) : MAXW'($signed(bus.i_opr2));

  mult_iter_step #(
    .W    (W),
    .STEP (STEP),
    .CW   (CW)
  ) u_step (
    .mag1_i  (mag1_q),
    .digit_i (mplr_q[STEP-1:0]),
    .cnt_i   (cnt_q),
    .acc_i   (acc_q),
    .acc_o   (step_acc)
  );

  assign prod = neg_q ? ('0 - acc_q) : acc_q;

  always_comb begin
    result = prod;
`ifdef MULT_ACC_EN
    unique case (amode_q)
      ACC_MADD: result = aval_q + prod;
      ACC_MSUB: result = aval_q - prod;
      default:  result = prod;
    endcase
`endif
  end

  // Datapath next-state
  always_comb begin
    mag1_d  = mag1_q;
    mplr_d  = mplr_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    valid_d = valid_q;
`ifdef MULT_ACC_EN
    amode_d = amode_q;
    aval_d  = aval_q;
`endif
    if (accept) begin
      mag1_d = W'(abs_w(opr1_x));
      mplr_d = W'(abs_w(opr2_x));
      neg_d  = ~bus.i_is_unsigned & (bus.i_opr1[W-1] ^ bus.i_opr2[W-1]);
      acc_d  = '0;
      cnt_d  = '0;
`ifdef MULT_ACC_EN
      amode_d = bus.i_acc_mode;
      aval_d  = {bus.i_acc_hi, bus.i_acc_lo};
`endif
    end
    if (state_q == CALC) begin
      acc_d  = step_acc;
      mplr_d = mplr_q >> STEP;
      cnt_d  = cnt_q + 1'b1;
    end
    if (state_q == FIX) begin
      hi_d    = result[2*W-1:W];
      lo_d    = result[W-1:0];
      valid_d = 1'b1;
    end
    if (state_q == DONE && bus.i_ready) valid_d = 1'b0;
    if (bus.i_flush) valid_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mag1_q  <= '0;
      mplr_q  <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      valid_q <= 1'b0;
`ifdef MULT_ACC_EN
      amode_q <= '0;
      aval_q  <= '0;
`endif
    end else begin
      mag1_q  <= mag1_d;
      mplr_q  <= mplr_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      valid_q <= valid_d;
`ifdef MULT_ACC_EN
      amode_q <= amode_d;
      aval_q  <= aval_d;
`endif
    end
  end

endmodule
